key_encode42: RTL and testbench

- 4-to-2 priority encoder for the four on-board push keys. It is the input-side counterpart of the 2-to-4 LED decoder: key presses become a 2-bit code that can drive the decoder directly.
- Each key is synchronised and debounced before encoding.
- A one-cycle valid strobe accompanies each new press.
- The last code is held until the next press.
- Sits between the board keys and any downstream decoder or display logic.

---
 rtl/key_encode42.sv | 87 ++++++++
 tb/tb_key_encode42.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/key_encode42.sv
// Four-key front end: synchronise, debounce and priority-encode active-low push keys
// into a 2-bit code with a one-cycle valid strobe per new press.
module key_encode42 #(
    parameter int DEBOUNCE_CYCLES = 240000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key,
    output logic [1:0] code,
    output logic       code_vld,
    output logic [3:0] pressed,
    output logic       multi
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] TC = CW'(DEBOUNCE_CYCLES - 1);

    logic [3:0]    sync1;
    logic [3:0]    sync2;
    logic [3:0]    db;
    logic [3:0]    db_next;
    logic [CW-1:0] cnt      [4];
    logic [CW-1:0] cnt_next [4];
    logic [3:0]    pressed_q;
    logic [3:0]    press_ev;
    logic [1:0]    enc;
    logic [2:0]    npress;

    // db holds the debounced raw level (1 = released); pressed is its inverse
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            db_next[i]  = db[i];
            cnt_next[i] = '0;
            if (sync2[i] != db[i]) begin
                if (cnt[i] == TC) begin
                    db_next[i] = ~db[i];
                end else begin
                    cnt_next[i] = cnt[i] + CW'(1);
                end
            end
        end
    end

    assign press_ev = pressed & ~pressed_q;

    // ascending scan so the highest-numbered press event wins
    always_comb begin
        enc = code;
        for (int i = 0; i < 4; i++) begin
            if (press_ev[i]) begin
                enc = 2'(i);
            end
        end
    end

    assign npress = {2'b00, pressed[0]} + {2'b00, pressed[1]}
                  + {2'b00, pressed[2]} + {2'b00, pressed[3]};

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1     <= 4'b1111;
            sync2     <= 4'b1111;
            db        <= 4'b1111;
            pressed   <= 4'b0000;
            pressed_q <= 4'b0000;
            code      <= 2'b00;
            code_vld  <= 1'b0;
            multi     <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1     <= key;
            sync2     <= sync1;
            db        <= db_next;
            pressed   <= ~db_next;
            pressed_q <= pressed;
            code      <= enc;
            code_vld  <= |press_ev;
            multi     <= (npress >= 3'd2);
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= cnt_next[i];
            end
        end
    end

endmodule

// File: tb/tb_key_encode42.sv
// Bench for key_encode42 with a short debounce: vector table plus hand-built corner
// sequences; strobes are checked against a timed scoreboard queue.
module tb_key_encode42;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] key;
    logic [1:0] code;
    logic       code_vld;
    logic [3:0] pressed;
    logic       multi;
    logic [3:0] led;

    int cyc   = 0;
    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [3:0] key;
        logic [3:0] prs;
        logic [1:0] code;
        logic       mlt;
    } vec_t;

    typedef struct {
        int         cyc;
        logic [1:0] code;
    } exp_t;

    vec_t vecs [6];
    exp_t sbq [$];

    key_encode42 #(.DEBOUNCE_CYCLES(D)) dut (
        .clk      (clk),
        .rst      (rst),
        .key      (key),
        .code     (code),
        .code_vld (code_vld),
        .pressed  (pressed),
        .multi    (multi)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // downstream 2-to-4 LED decoder, loaded on each strobe
    always @(posedge clk) begin
        if (rst) led <= 4'b0000;
        else if (code_vld) led <= 4'b0001 << code;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0d, required %0d", name, cyc, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic drive(input logic [3:0] k, output int e);
        key = k;
        e = cyc + 1;
    endtask

    task automatic expect_strobe(input int c, input logic [1:0] cd);
        exp_t x;
        x.cyc  = c;
        x.code = cd;
        sbq.push_back(x);
    endtask

    // strobe monitor: every code_vld must match the head of the queue in time and code
    always @(negedge clk) begin
        if (sbq.size() > 0 && cyc > sbq[0].cyc) begin
            chk("missed_strobe", 0, 1);
            void'(sbq.pop_front());
        end
        if (code_vld) begin
            if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
                chk("strobe_code", int'(code), int'(sbq[0].code));
                void'(sbq.pop_front());
            end else begin
                chk("unexpected_strobe", 1, 0);
            end
        end
    end

    initial begin
        int e;
        int e2;
        int e3;

        vecs[0] = '{key: 4'b1101, prs: 4'b0010, code: 2'd1, mlt: 1'b0};
        vecs[1] = '{key: 4'b0110, prs: 4'b1001, code: 2'd3, mlt: 1'b1};
        vecs[2] = '{key: 4'b1110, prs: 4'b0001, code: 2'd0, mlt: 1'b0};
        vecs[3] = '{key: 4'b1010, prs: 4'b0101, code: 2'd2, mlt: 1'b1};
        vecs[4] = '{key: 4'b0111, prs: 4'b1000, code: 2'd3, mlt: 1'b0};
        vecs[5] = '{key: 4'b0000, prs: 4'b1111, code: 2'd3, mlt: 1'b1};

        rst = 1'b1;
        key = 4'b1111;
        @(negedge clk);
        wait_cyc(2);
        chk("rst_code", int'(code), 0);
        chk("rst_vld", int'(code_vld), 0);
        chk("rst_pressed", int'(pressed), 0);
        chk("rst_multi", int'(multi), 0);
        wait_cyc(3);
        rst = 1'b0;
        wait_cyc(cyc + 3);

        // press/release table
        foreach (vecs[i]) begin
            drive(vecs[i].key, e);
            expect_strobe(e + D + 2, vecs[i].code);
            wait_cyc(e + D);
            chk("pressed_early", int'(pressed), 0);
            wait_cyc(e + D + 1);
            chk("pressed_set", int'(pressed), int'(vecs[i].prs));
            chk("multi_lag", int'(multi), 0);
            wait_cyc(e + D + 2);
            chk("code_new", int'(code), int'(vecs[i].code));
            chk("multi_set", int'(multi), int'(vecs[i].mlt));
            wait_cyc(e + D + 4);
            drive(4'b1111, e);
            wait_cyc(e + D);
            chk("pressed_held", int'(pressed), int'(vecs[i].prs));
            wait_cyc(e + D + 1);
            chk("pressed_clr", int'(pressed), 0);
            wait_cyc(e + D + 3);
            chk("code_hold", int'(code), int'(vecs[i].code));
            chk("multi_clr", int'(multi), 0);
        end

        // bounce on key[2]: never reaches the threshold
        for (int t = 0; t < 20; t++) begin
            key = ((t / 2) % 2 == 0) ? 4'b1011 : 4'b1111;
            wait_cyc(cyc + 1);
            if (pressed != 4'b0000) chk("bounce_pressed", int'(pressed), 0);
        end
        key = 4'b1111;
        wait_cyc(cyc + D + 3);
        chk("bounce_final", int'(pressed), 0);

        // overlapping press: key[0] held, then key[2]
        drive(4'b1110, e);
        expect_strobe(e + D + 2, 2'd0);
        wait_cyc(e + D + 3);
        drive(4'b1010, e2);
        expect_strobe(e2 + D + 2, 2'd2);
        wait_cyc(e2 + D + 1);
        chk("ovl_pressed", int'(pressed), 4'b0101);
        chk("ovl_multi0", int'(multi), 0);
        wait_cyc(e2 + D + 2);
        chk("ovl_multi1", int'(multi), 1);
        chk("ovl_code", int'(code), 2);
        wait_cyc(e2 + D + 4);
        drive(4'b1011, e3);
        wait_cyc(e3 + D + 1);
        chk("ovl_rel_pressed", int'(pressed), 4'b0100);
        chk("ovl_rel_multi1", int'(multi), 1);
        wait_cyc(e3 + D + 2);
        chk("ovl_rel_multi0", int'(multi), 0);
        chk("ovl_rel_code", int'(code), 2);
        drive(4'b1111, e);
        wait_cyc(e + D + 3);

        // reset while key[3] is mid-debounce
        drive(4'b0111, e);
        wait_cyc(e + 1);
        rst = 1'b1;
        wait_cyc(e + 2);
        chk("mid_rst_code", int'(code), 0);
        chk("mid_rst_pressed", int'(pressed), 0);
        chk("mid_rst_vld", int'(code_vld), 0);
        wait_cyc(e + 3);
        chk("mid_rst_multi", int'(multi), 0);
        rst = 1'b0;
        e = cyc + 1;
        expect_strobe(e + D + 2, 2'd3);
        wait_cyc(e + D);
        chk("post_rst_early", int'(pressed), 0);
        wait_cyc(e + D + 1);
        chk("post_rst_pressed", int'(pressed), 4'b1000);
        wait_cyc(e + D + 2);
        chk("post_rst_code", int'(code), 3);
        drive(4'b1111, e);
        wait_cyc(e + D + 3);

        // decoder round-trip for each key
        for (int k = 0; k < 4; k++) begin
            logic [3:0] kv;
            logic [3:0] oh;
            oh = 4'b0001 << k;
            kv = ~oh;
            drive(kv, e);
            expect_strobe(e + D + 2, 2'(k));
            wait_cyc(e + D + 2);
            chk("led_before", int'(led == oh && k != 0 ? 1 : 0), 0);
            wait_cyc(e + D + 3);
            chk("led_onehot", int'(led), int'(oh));
            drive(4'b1111, e);
            wait_cyc(e + D + 3);
            chk("led_hold", int'(led), int'(oh));
        end

        wait_cyc(cyc + 10);
        chk("scoreboard_empty", sbq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
